// File: rtl/cpu3_pkg.sv
// Shared types and helpers for the cpu3 multicycle accumulator processor.
package cpu3_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_ADDI  = 3'd4,
    OP_BNZ   = 3'd5,
    OP_JMP   = 3'd6,
    OP_HALT  = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WB    = 2'd2,
    HALT  = 2'd3
  } state_t;

  // First I/O address: the top N_IO words of the operand space are channels.
  function automatic int io_base(input int aw, input int n_io);
    return (2 ** aw) - n_io;
  endfunction

endpackage

// File: rtl/cpu3_io.sv
// Memory-mapped I/O bank: N_IO latched output registers and an input read mux.
module cpu3_io #(
  parameter int WORD_W = 8,
  parameter int N_IO   = 2,
  parameter int SW     = (N_IO > 1) ? $clog2(N_IO) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   we,
  input  logic [SW-1:0]          sel,
  input  logic [WORD_W-1:0]      wdata,
  input  logic [N_IO*WORD_W-1:0] in_ports,
  output logic [WORD_W-1:0]      rdata,
  output logic [N_IO*WORD_W-1:0] out_ports
);

  logic [WORD_W-1:0] out_q [N_IO];

  for (genvar i = 0; i < N_IO; i++) begin : g_ch
    // Output latch for channel i; written only when selected by a STORE.
    always_ff @(posedge clock) begin
      if (reset)
        out_q[i] <= '0;
      else if (we && int'(sel) == i)
        out_q[i] <= wdata;
    end
    assign out_ports[i*WORD_W +: WORD_W] = out_q[i];
  end

  // Input channel select; an unused select code reads as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_IO; i++)
      if (int'(sel) == i) rdata = in_ports[i*WORD_W +: WORD_W];
  end

endmodule

// File: rtl/cpu3_mmio.sv
// Multicycle accumulator CPU: FETCH/EXEC/WB FSM, inline ROM/RAM, MMIO bank.
module cpu3_mmio
  import cpu3_pkg::*;
#(
  parameter int    WORD_W    = 8,
  parameter int    OP_W      = 3,
  parameter int    N_IO      = 2,
  parameter string IMEM_FILE = "prog.hex"
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      step,
  input  logic [N_IO*WORD_W-1:0]    in_ports,
  output logic [N_IO*WORD_W-1:0]    out_ports,
  output logic [WORD_W-OP_W-1:0]    pc,
  output logic [WORD_W-1:0]         acc,
  output logic                      z_flag,
  output logic                      halted
);

  localparam int AW      = WORD_W - OP_W;
  localparam int DEPTH   = 2 ** AW;
  localparam int IO_BASE = io_base(AW, N_IO);
  localparam int SW      = (N_IO > 1) ? $clog2(N_IO) : 1;

  logic [WORD_W-1:0] imem [DEPTH];
  logic [WORD_W-1:0] dmem [DEPTH];

  state_t            state;
  logic [WORD_W-1:0] ir;
  logic [WORD_W-1:0] ram_q, io_q, io_rdata;
  logic              src_io;
  logic [WORD_W-1:0] opnd_val, wb_val, addi_val;
  opcode_t           op;
  logic [AW-1:0]     opnd;
  logic              is_io, io_we;
  logic [SW-1:0]     io_sel;

  assign op     = opcode_t'(ir[WORD_W-1 -: OP_W]);
  assign opnd   = ir[AW-1:0];
  assign is_io  = opnd >= AW'(IO_BASE);
  assign io_sel = SW'(opnd - AW'(IO_BASE));
  assign io_we  = (state == EXEC) && (op == OP_STORE) && is_io && !reset;

  cpu3_io #(.WORD_W(WORD_W), .N_IO(N_IO), .SW(SW)) u_io (
    .clock    (clock),
    .reset    (reset),
    .we       (io_we),
    .sel      (io_sel),
    .wdata    (acc),
    .in_ports (in_ports),
    .rdata    (io_rdata),
    .out_ports(out_ports)
  );

  // Data RAM: STORE writes, LOAD/ADD/SUB read, both in EXEC; never reset.
  always_ff @(posedge clock) begin
    if (state == EXEC && !is_io) begin
      if (op == OP_STORE && !reset) dmem[opnd] <= acc;
      ram_q <= dmem[opnd];
    end
  end

  // Writeback value and immediate add result.
  always_comb begin
    opnd_val = src_io ? io_q : ram_q;
    addi_val = acc + WORD_W'(opnd);
    case (op)
      OP_ADD:  wb_val = acc + opnd_val;
      OP_SUB:  wb_val = acc - opnd_val;
      default: wb_val = opnd_val;
    endcase
  end

  // Control FSM; branches in EXEC overwrite the pc increment from FETCH.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= FETCH;
      pc     <= '0;
      acc    <= '0;
      z_flag <= 1'b1;
      ir     <= '0;
      halted <= 1'b0;
      io_q   <= '0;
      src_io <= 1'b0;
    end else begin
      case (state)
        FETCH: if (run || step) begin
          ir    <= imem[pc];
          pc    <= pc + AW'(1);
          state <= EXEC;
        end
        EXEC: case (op)
          OP_LOAD, OP_ADD, OP_SUB: begin
            io_q   <= io_rdata;
            src_io <= is_io;
            state  <= WB;
          end
          OP_ADDI: begin
            acc    <= addi_val;
            z_flag <= (addi_val == '0);
            state  <= FETCH;
          end
          OP_BNZ: begin
            if (!z_flag) pc <= opnd;
            state <= FETCH;
          end
          OP_JMP: begin
            pc    <= opnd;
            state <= FETCH;
          end
          OP_HALT: begin
            halted <= 1'b1;
            state  <= HALT;
          end
          default: state <= FETCH;
        endcase
        WB: begin
          acc    <= wb_val;
          z_flag <= (wb_val == '0);
          state  <= FETCH;
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu3_mmio.sv
// Bench for cpu3_mmio: instruction-level ISA model, directed and random programs.
module tb_cpu3_mmio;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run   = 1'b1;
  logic        step  = 1'b0;
  logic [15:0] in_ports = '0;
  logic [15:0] out_ports;
  logic [4:0]  pc;
  logic [7:0]  acc;
  logic        z_flag, halted;

  cpu3_mmio #(.WORD_W(8), .OP_W(3), .N_IO(2), .IMEM_FILE("")) dut (
    .clock(clock), .reset(reset), .run(run), .step(step),
    .in_ports(in_ports), .out_ports(out_ports), .pc(pc), .acc(acc),
    .z_flag(z_flag), .halted(halted)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] prog [32];
  logic [7:0] mem_init [32];

  // Architectural model state
  logic [4:0] m_pc;
  logic [7:0] m_acc;
  logic       m_z, m_halt;
  logic [7:0] m_out [2];
  logic [7:0] m_mem [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},     32'(pc),        32'(m_pc));
    chk({tag, ".acc"},    32'(acc),       32'(m_acc));
    chk({tag, ".z"},      32'(z_flag),    32'(m_z));
    chk({tag, ".out"},    32'(out_ports), 32'({m_out[1], m_out[0]}));
    chk({tag, ".halted"}, 32'(halted),    32'(m_halt));
  endtask

  task automatic model_reset();
    m_pc = '0; m_acc = '0; m_z = 1'b1; m_halt = 1'b0;
    m_out[0] = '0; m_out[1] = '0;
  endtask

  task automatic set_acc(input logic [7:0] v);
    m_acc = v;
    m_z   = (v == 8'd0);
  endtask

  // Execute one whole instruction; lat = clock cycles it takes.
  task automatic model_step(output int lat);
    logic [7:0] ins, v;
    logic [2:0] op;
    logic [4:0] a;
    int         ch;
    lat = 2;
    if (m_halt) return;
    ins  = prog[m_pc];
    op   = ins[7:5];
    a    = ins[4:0];
    m_pc = m_pc + 5'd1;
    ch   = int'(a) - 30;
    v    = (a >= 5'd30) ? in_ports[ch*8 +: 8] : m_mem[a];
    case (op)
      3'd0: begin set_acc(v); lat = 3; end
      3'd1: if (a >= 5'd30) m_out[ch] = m_acc; else m_mem[a] = m_acc;
      3'd2: begin set_acc(m_acc + v); lat = 3; end
      3'd3: begin set_acc(m_acc - v); lat = 3; end
      3'd4: set_acc(m_acc + {3'b000, a});
      3'd5: if (!m_z) m_pc = a;
      3'd6: m_pc = a;
      default: m_halt = 1'b1;
    endcase
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) begin
      prog[i]     = 8'hE0;
      mem_init[i] = 8'(i * 7 + 3);
    end
  endtask

  // Hold reset two cycles while loading ROM/RAM, check reset state, release.
  task automatic load_and_reset(input string tag);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dut.imem[i] = prog[i];
      dut.dmem[i] = mem_init[i];
      m_mem[i]    = mem_init[i];
    end
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    check_all({tag, ".rst"});
    reset = 1'b0;
  endtask

  task automatic run_instrs(input int n, input string tag);
    int lat;
    for (int k = 0; k < n; k++) begin
      model_step(lat);
      repeat (lat) @(posedge clock);
      #1;
      check_all(tag);
    end
  endtask

  initial begin
    int lat;

    // Reset asserted mid-program
    clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = 8'($urandom_range(0, 8'hBF));
    in_ports = 16'($urandom);
    load_and_reset("t1");
    run_instrs(4, "t1.run");
    repeat ($urandom_range(0, 1)) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    check_all("t1.midrst");

    // LOAD 30, ADDI 5, STORE 31 with cycle-exact output timing
    clear_prog();
    prog[0] = 8'h1E; prog[1] = 8'h85; prog[2] = 8'h3F; prog[3] = 8'hC3;
    in_ports = 16'h0012;
    load_and_reset("t2");
    repeat (6) @(posedge clock);
    #1 chk("t2.out_c6", 32'(out_ports), 32'h0000);
    @(posedge clock);
    #1 chk("t2.out_c7", 32'(out_ports), 32'h1700);
    for (int k = 0; k < 3; k++) model_step(lat);
    check_all("t2.end");
    run_instrs(2, "t2.spin");

    // Countdown loop: SUB 10 / BNZ 1 from acc=3
    clear_prog();
    mem_init[10] = 8'd1;
    prog[0] = 8'h83; prog[1] = 8'h6A; prog[2] = 8'hA1; prog[3] = 8'hE0;
    load_and_reset("t3");
    run_instrs(1, "t3.addi");
    repeat (15) @(posedge clock);
    #1;
    for (int k = 0; k < 6; k++) model_step(lat);
    check_all("t3.loop");
    chk("t3.pc_out", 32'(pc), 32'd3);
    run_instrs(1, "t3.halt");

    // Single-step
    clear_prog();
    prog[0] = 8'h85;
    run = 1'b0;
    load_and_reset("t4");
    repeat (3) @(posedge clock);
    #1 check_all("t4.idle");
    step = 1'b1;
    @(posedge clock);
    #1 step = 1'b0;
    @(posedge clock);
    #1;
    model_step(lat);
    check_all("t4.step");
    repeat (10) begin
      @(posedge clock);
      #1 check_all("t4.hold");
    end
    run = 1'b1;

    // HALT is absorbing
    clear_prog();
    for (int i = 0; i < 4; i++) prog[i] = 8'h81;
    load_and_reset("t5");
    run_instrs(5, "t5.run");
    chk("t5.pc5", 32'(pc), 32'd5);
    repeat (10) begin
      run  = 1'($urandom);
      step = 1'($urandom);
      @(posedge clock);
      #1 check_all("t5.frozen");
    end
    run = 1'b1; step = 1'b0;
    load_and_reset("t5.clr");

    // Reset in WB of LOAD suppresses the acc write; RAM survives
    clear_prog();
    mem_init[2] = 8'hAA;
    prog[0] = 8'h02;
    load_and_reset("t6a");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
    check_all("t6a.wbrst");
    chk("t6a.mem2", 32'(dut.dmem[2]), 32'hAA);
    // Reset during EXEC of STORE 31 suppresses the output write
    prog[0] = 8'h87; prog[1] = 8'h3F;
    load_and_reset("t6b");
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
    check_all("t6b.strst");

    // pc wrap after fetch at 31
    clear_prog();
    prog[0] = 8'hDF; prog[31] = 8'h81;
    load_and_reset("t7");
    run_instrs(4, "t7.wrap");

    // Random programs
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 32; i++) begin
        prog[i]     = 8'($urandom);
        mem_init[i] = 8'($urandom);
      end
      in_ports = 16'($urandom);
      load_and_reset("rnd");
      run_instrs(25, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
